// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGE_BITS resolved per clock, valid/ready on both sides.
// Define ADDER_SAT_EN to clamp the final result (add overflow -> all ones, sub borrow -> zero).
module pipelined_rca_adder #(
  parameter int WIDTH      = 4,
  parameter int STAGE_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NS = WIDTH / STAGE_BITS;
  localparam int SB = STAGE_BITS;

  if (WIDTH < 1 || STAGE_BITS < 1 || (WIDTH % STAGE_BITS) != 0) begin : g_bad_cfg
    $error("pipelined_rca_adder: WIDTH must be a positive multiple of STAGE_BITS");
  end

  // st_a[k] carries the unconsumed A slices shifted down, with finished sum slices
  // entering from the top; after the last stage it holds the complete sum.
  logic [NS-1:0]    st_v, st_c;
  logic [WIDTH-1:0] st_a [NS];
  logic [WIDTH-1:0] st_b [NS];

  logic [NS-1:0]    ent_v, ent_c, nxt_c;
  logic [WIDTH-1:0] ent_a [NS];
  logic [WIDTH-1:0] ent_b [NS];
  logic [WIDTH-1:0] nxt_a [NS];
  logic [WIDTH-1:0] nxt_b [NS];
  logic [SB:0]      slice;
  logic             advance;

`ifdef ADDER_SAT_EN
  logic [NS-1:0] st_s, ent_s;
`endif

  assign out_valid = st_v[NS-1];
  assign sum       = st_a[NS-1];
  assign cout      = st_c[NS-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && rst_n;

  // Stage inputs: stage 0 takes the port operands, stage k takes register k-1.
  always_comb begin
    // NOTE: every combinational output gets a value on every path; a missed
    // branch would silently infer a latch.
    ent_v    = '0;
    ent_c    = '0;
    ent_v[0] = in_valid && in_ready;
    ent_c[0] = sub | cin;
    ent_a[0] = a;
    ent_b[0] = sub ? ~b : b;
    for (int k = 1; k < NS; k++) begin
      ent_v[k] = st_v[k-1];
      ent_c[k] = st_c[k-1];
      ent_a[k] = st_a[k-1];
      ent_b[k] = st_b[k-1];
    end
  end

`ifdef ADDER_SAT_EN
  always_comb begin
    ent_s    = '0;
    ent_s[0] = sub;
    for (int k = 1; k < NS; k++) begin
      ent_s[k] = st_s[k-1];
    end
  end
`endif

  always_comb begin
    slice = '0;
    nxt_c = '0;
    for (int k = 0; k < NS; k++) begin
      slice    = {1'b0, ent_a[k][SB-1:0]} + {1'b0, ent_b[k][SB-1:0]} + {{SB{1'b0}}, ent_c[k]};
      nxt_a[k] = (ent_a[k] >> SB) | (WIDTH'(slice[SB-1:0]) << (WIDTH - SB));
      nxt_b[k] = ent_b[k] >> SB;
      nxt_c[k] = slice[SB];
    end
`ifdef ADDER_SAT_EN
    if (!ent_s[NS-1] && nxt_c[NS-1]) begin
      nxt_a[NS-1] = '1;
    end else if (ent_s[NS-1] && !nxt_c[NS-1]) begin
      nxt_a[NS-1] = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand/sum registers are cleared too, so sum/cout read 0 after
      // reset and a flushed pipeline never exposes stale data.
      st_v <= '0;
      st_c <= '0;
      for (int k = 0; k < NS; k++) begin
        st_a[k] <= '0;
        st_b[k] <= '0;
      end
    end else if (advance) begin
      // NOTE: non-blocking so every stage samples its neighbour's old value.
      st_v <= ent_v;
      st_c <= nxt_c;
      for (int k = 0; k < NS; k++) begin
        st_a[k] <= nxt_a[k];
        st_b[k] <= nxt_b[k];
      end
    end
  end

`ifdef ADDER_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_s <= '0;
    end else if (advance) begin
      st_s <= ent_s;
    end
  end
`endif

endmodule
